// File: rtl/tape_pkg.sv
// Shared definitions for the cassette tape recorder: FSM state encoding and
// default timing constants (all timing values are in ce_tape ticks).
package tape_pkg;

   localparam int THRESH_DEF  = 12;
   localparam int MIN_P_DEF   = 3;
   localparam int TIMEOUT_DEF = 4095;
   localparam int PERIOD_W    = 12;

   typedef enum logic [2:0] {
      IDLE,
      HUNT,
      DATA,
      STOP1,
      STOP2
   } tape_state_t;

endpackage

// File: rtl/tape_edge_timer.sv
// Rising-edge detector and period timer for the cassette signal. Each edge
// whose period reaches MIN_P yields one classified bit: '1' for short periods
// (<= THRESH), '0' for long ones. Shorter periods are glitches and leave the
// running period count untouched.
module tape_edge_timer
   import tape_pkg::*;
#(
   parameter int THRESH = THRESH_DEF,
   parameter int MIN_P  = MIN_P_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ce_tape,
   input  logic cass_in,
   output logic bit_valid,
   output logic bit_val
);

   localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
   localparam logic [PERIOD_W-1:0] MIN_P_C    = PERIOD_W'(MIN_P);
   localparam logic [PERIOD_W-1:0] THRESH_C   = PERIOD_W'(THRESH);

   logic                cass_q;
   logic                cass_last;
   logic [PERIOD_W-1:0] period_cnt;
   logic [PERIOD_W-1:0] period_inc;
   logic                rise;

   // Period including the current tick, saturating so long silences stay '0'.
   always_comb begin
      period_inc = period_cnt;
      if (period_cnt != PERIOD_MAX) begin
         period_inc = period_cnt + 1'b1;
      end
   end

   assign rise      = ce_tape & cass_q & ~cass_last;
   assign bit_valid = rise && (period_inc >= MIN_P_C);
   assign bit_val   = (period_inc <= THRESH_C);

   // Input register plus tick-rate edge history and period counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cass_q     <= 1'b0;
         cass_last  <= 1'b0;
         period_cnt <= '0;
      end else begin
         cass_q <= cass_in;
         if (ce_tape) begin
            cass_last  <= cass_q;
            period_cnt <= bit_valid ? '0 : period_inc;
         end
      end
   end

endmodule

// File: rtl/tape_rec.sv
// Cassette recorder: frames classified tape bits into bytes (start '0',
// 8 data bits MSB first, two stop '1') and writes each byte to sequential
// addresses. Define TAPE_REC_ERRCNT_EN to build the framing error counter;
// without it err_cnt is tied to zero.
module tape_rec
   import tape_pkg::*;
#(
   parameter int THRESH  = THRESH_DEF,
   parameter int MIN_P   = MIN_P_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce_tape,
   input  logic        enable,
   input  logic        cass_in,
   output logic        wr,
   output logic [15:0] addr,
   output logic [7:0]  data,
   output logic [15:0] length,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [7:0]  err_cnt
);

   localparam logic [PERIOD_W-1:0] IDLE_MAX  = '1;
   localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);

   tape_state_t         state;
   tape_state_t         next_state;
   logic                bit_valid;
   logic                bit_val;
   logic                enable_q;
   logic                arm;
   logic                arm_go;
   logic                timeout_hit;
   logic                write_byte;
   logic                timeout_end;
   logic [2:0]          bit_cnt;
   logic [7:0]          shift_q;
   logic [PERIOD_W-1:0] idle_cnt;
   logic                wr_q;
   logic [15:0]         addr_q;
   logic [7:0]          data_q;
   logic [15:0]         length_q;
   logic                done_q;
   logic                overflow_q;

   tape_edge_timer #(
      .THRESH (THRESH),
      .MIN_P  (MIN_P)
   ) u_edge_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce_tape   (ce_tape),
      .cass_in   (cass_in),
      .bit_valid (bit_valid),
      .bit_val   (bit_val)
   );

   assign arm         = enable & ~enable_q;
   assign arm_go      = (state == IDLE) && (next_state == HUNT);
   assign timeout_hit = (idle_cnt >= TIMEOUT_C) && ((length_q != 16'd0) || overflow_q);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Framing FSM: disarm beats timeout, timeout beats any bit arriving.
   always_comb begin
      next_state  = state;
      write_byte  = 1'b0;
      timeout_end = 1'b0;
      if (!enable) begin
         next_state = IDLE;
      end else if ((state != IDLE) && timeout_hit) begin
         next_state  = IDLE;
         timeout_end = 1'b1;
      end else begin
         case (state)
            IDLE:  if (arm) next_state = HUNT;
            HUNT:  if (bit_valid && !bit_val) next_state = DATA;
            DATA:  if (bit_valid && (bit_cnt == 3'd7)) next_state = STOP1;
            STOP1: if (bit_valid) next_state = bit_val ? STOP2 : HUNT;
            STOP2: begin
               if (bit_valid) begin
                  next_state = HUNT;
                  write_byte = bit_val;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Byte assembly, write strobe, buffer length and end-of-recording flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         enable_q   <= 1'b0;
         bit_cnt    <= '0;
         shift_q    <= '0;
         idle_cnt   <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         length_q   <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         enable_q <= enable;
         wr_q     <= 1'b0;
         if ((state == IDLE) || bit_valid) begin
            idle_cnt <= '0;
         end else if (ce_tape && (idle_cnt != IDLE_MAX)) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
         if (state == HUNT) begin
            bit_cnt <= '0;
         end
         if ((state == DATA) && bit_valid) begin
            shift_q <= {shift_q[6:0], bit_val};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (write_byte && !overflow_q) begin
            wr_q   <= 1'b1;
            addr_q <= length_q;
            data_q <= shift_q;
         end
         if (wr_q) begin
            if (length_q == 16'hFFFF) begin
               overflow_q <= 1'b1;
            end
            length_q <= length_q + 1'b1;
         end
         if (timeout_end) begin
            done_q <= 1'b1;
         end
         if (arm_go) begin
            length_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
         end
      end
   end

`ifdef TAPE_REC_ERRCNT_EN
   logic [7:0] err_q;
   logic       frame_err;

   assign frame_err = enable && !timeout_end && bit_valid && !bit_val &&
                      ((state == STOP1) || (state == STOP2));

   // Saturating framing error counter, restarted with each recording.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_q <= '0;
      end else if (arm_go) begin
         err_q <= '0;
      end else if (frame_err && (err_q != 8'hFF)) begin
         err_q <= err_q + 1'b1;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'h00;
`endif

   assign wr       = wr_q;
   assign addr     = addr_q;
   assign data     = data_q;
   assign length   = length_q;
   assign done     = done_q;
   assign overflow = overflow_q;
   assign busy     = (state == DATA) || (state == STOP1) || (state == STOP2);

endmodule

// File: tb/tb_tape_rec.sv
// Testbench for tape_rec: drives tape bit periods tick by tick, queues the
// expected address/data of every byte that should be written, and compares
// each write strobe against the head of that queue.
module tb_tape_rec;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ce_tape;
   logic        enable;
   logic        cass_in;
   logic        wr;
   logic [15:0] addr;
   logic [7:0]  data;
   logic [15:0] length;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [7:0]  err_cnt;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [23:0] exp_q[$];
   logic [23:0] exp_item;

`ifdef TAPE_REC_ERRCNT_EN
   localparam logic [7:0] EXP_ERR = 8'd1;
`else
   localparam logic [7:0] EXP_ERR = 8'd0;
`endif

   tape_rec #(
      .THRESH  (12),
      .MIN_P   (3),
      .TIMEOUT (4095)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .ce_tape  (ce_tape),
      .enable   (enable),
      .cass_in  (cass_in),
      .wr       (wr),
      .addr     (addr),
      .data     (data),
      .length   (length),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .err_cnt  (err_cnt)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Every write strobe must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (wr === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL wr_unexpected: got addr=%h data=%h, required no write", addr, data);
            end else begin
               exp_item = exp_q.pop_front();
               if ({addr, data} !== exp_item) begin
                  n_fail++;
                  $display("[TB] FAIL wr_content: got addr=%h data=%h, required addr=%h data=%h",
                           addr, data, exp_item[23:8], exp_item[7:0]);
               end
            end
         end
      end
   end

   // One tape tick: hold the cassette level, then pulse ce_tape for one clk.
   task automatic tick(input logic level);
      cass_in = level;
      repeat (3) @(negedge clk);
      ce_tape = 1'b1;
      @(negedge clk);
      ce_tape = 1'b0;
   endtask

   // One period starting with a rising edge; a glitch adds an edge 2 ticks in.
   task automatic send_period(input int p, input bit glitch);
      if (glitch) begin
         tick(1'b1);
         tick(1'b0);
         tick(1'b1);
         for (int i = 3; i < p; i++) tick(1'b0);
      end else begin
         for (int i = 0; i < p; i++) tick(i < p / 2);
      end
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      send_period(b ? 8 : 20, glitch);
   endtask

   // Full frame; the second stop bit is classified by the caller's next edge.
   task automatic applyStimulus(input logic [7:0] value, input logic stop1, input int glitch_idx,
                                input bit expect_wr, input logic [15:0] exp_addr);
      if (expect_wr) exp_q.push_back({exp_addr, value});
      send_bit(1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) send_bit(value[i], i == glitch_idx);
      send_bit(stop1, 1'b0);
      send_bit(1'b1, 1'b0);
   endtask

   // Establish a reference edge, arm with a fresh enable rising edge, add leader.
   task automatic lead_in_and_arm();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      ce_tape = 1'b0;
      cass_in = 1'b0;
      repeat (3) @(negedge clk);
      enable  = 1'b1;
      cass_in = 1'b1;
      ce_tape = 1'b1;
      @(negedge clk);
      ce_tape = 1'b0;
      enable  = 1'b0;
      cass_in = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({wr, busy, done, overflow} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b, required 0000", {wr, busy, done, overflow});
      end
      n_checks++;
      if ({addr, data} !== 24'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_addr_data: got %h, required 000000", {addr, data});
      end
      n_checks++;
      if (length !== 16'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_length: got %h, required 0000", length);
      end
      n_checks++;
      if (err_cnt !== 8'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_err_cnt: got %h, required 00", err_cnt);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL post_reset_busy: got %b, required 0", busy);
      end
   endtask

   task automatic test_single_byte();
      lead_in_and_arm();
      n_checks++;
      if ({length, done, overflow} !== 18'h0) begin
         n_fail++;
         $display("[TB] FAIL arm_clear: got length=%h done=%b ovf=%b, required 0", length, done, overflow);
      end
      applyStimulus(8'hA5, 1'b1, -1, 1'b1, 16'h0000);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL busy_in_frame: got %b, required 1", busy);
      end
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL single_wr_missing: got %0d pending, required 0", exp_q.size());
      end
      n_checks++;
      if (length !== 16'd1) begin
         n_fail++;
         $display("[TB] FAIL single_length: got %h, required 0001", length);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL busy_after_byte: got %b, required 0", busy);
      end
   endtask

   task automatic test_multi_timeout();
      lead_in_and_arm();
      n_checks++;
      if (length !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL rearm_length: got %h, required 0000", length);
      end
      applyStimulus(8'h00, 1'b1, -1, 1'b1, 16'd0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b1, -1, 1'b1, 16'd1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      applyStimulus(8'h3C, 1'b1, -1, 1'b1, 16'd2);
      send_bit(1'b1, 1'b0);
      n_checks++;
      if (exp_q.size() != 0 || length !== 16'd3) begin
         n_fail++;
         $display("[TB] FAIL multi_writes: got pending=%0d length=%h, required 0 and 0003", exp_q.size(), length);
      end
      for (int i = 0; i < 4087; i++) tick(1'b0);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL done_early: got %b after 4094 idle ticks, required 0", done);
      end
      tick(1'b0);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL done_timeout: got %b after 4095 idle ticks, required 1", done);
      end
      n_checks++;
      if (length !== 16'd3) begin
         n_fail++;
         $display("[TB] FAIL length_after_done: got %h, required 0003", length);
      end
   endtask

   task automatic test_framing_err();
      lead_in_and_arm();
      applyStimulus(8'h55, 1'b0, -1, 1'b0, 16'd0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      n_checks++;
      if (err_cnt !== EXP_ERR) begin
         n_fail++;
         $display("[TB] FAIL framing_err_cnt: got %h, required %h", err_cnt, EXP_ERR);
      end
      n_checks++;
      if (length !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL framing_length: got %h, required 0000", length);
      end
      applyStimulus(8'h55, 1'b1, -1, 1'b1, 16'd0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      n_checks++;
      if (exp_q.size() != 0 || length !== 16'd1) begin
         n_fail++;
         $display("[TB] FAIL after_error_byte: got pending=%0d length=%h, required 0 and 0001", exp_q.size(), length);
      end
   endtask

   task automatic test_glitch();
      lead_in_and_arm();
      applyStimulus(8'h81, 1'b1, 6, 1'b1, 16'd0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      n_checks++;
      if (exp_q.size() != 0 || length !== 16'd1) begin
         n_fail++;
         $display("[TB] FAIL glitch_byte: got pending=%0d length=%h, required 0 and 0001", exp_q.size(), length);
      end
   endtask

   task automatic test_disarm();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      tick(1'b1);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL busy_mid_data: got %b, required 1", busy);
      end
      enable = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL disarm_idle: got busy=%b, required 0", busy);
      end
      n_checks++;
      if (length !== 16'd1 || done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL disarm_hold: got length=%h done=%b, required 0001 and 0", length, done);
      end
      enable = 1'b1;
      @(negedge clk);
      n_checks++;
      if (length !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL rearm_clear: got %h, required 0000", length);
      end
   endtask

   task automatic test_overflow();
      lead_in_and_arm();
      force dut.length_q = 16'hFFFF;
      @(negedge clk);
      release dut.length_q;
      @(negedge clk);
      n_checks++;
      if (length !== 16'hFFFF) begin
         n_fail++;
         $display("[TB] FAIL length_preload: got %h, required FFFF", length);
      end
      applyStimulus(8'h5A, 1'b1, -1, 1'b1, 16'hFFFF);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      n_checks++;
      if (overflow !== 1'b1 || length !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL overflow_set: got ovf=%b length=%h, required 1 and 0000", overflow, length);
      end
      applyStimulus(8'hC3, 1'b1, -1, 1'b0, 16'd0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      n_checks++;
      if (exp_q.size() != 0 || overflow !== 1'b1 || length !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL overflow_drop: got pending=%0d ovf=%b length=%h, required 0, 1, 0000",
                  exp_q.size(), overflow, length);
      end
   endtask

   task automatic test_reset_midframe();
      lead_in_and_arm();
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      tick(1'b1);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL busy_before_reset: got %b, required 1", busy);
      end
      reset_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || length !== 16'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midframe_reset: got busy=%b length=%h ovf=%b, required 0", busy, length, overflow);
      end
      enable  = 1'b0;
      reset_n = 1'b1;
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      n_checks++;
      if (exp_q.size() != 0 || length !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL no_write_after_reset: got pending=%0d length=%h, required 0 and 0000", exp_q.size(), length);
      end
   endtask

   // Run all scenarios in order, then report.
   initial begin
      test_reset();
      test_single_byte();
      test_multi_timeout();
      test_framing_err();
      test_glitch();
      test_disarm();
      test_overflow();
      test_reset_midframe();
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
